mem_arbiter: RTL

Two-port arbiter and sequencer in front of the single-port synchronous byte-addressed memory. It shares the memory between the instruction-fetch port (word reads only) and the load/store data port (byte/halfword/word, read or write). It guarantees that memRead and memWrite are never active together, rejects misaligned or invalid accesses, and sign- or zero-extends sub-word loads. It sits between the RV32I core's fetch/LSU stages and the memory.

---
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port byte memory between instruction fetch
// and load/store. It rejects illegal accesses and extends sub-word loads.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  iReqValid,
  input  logic [ADDR_WIDTH-1:0] iAddr,
  output logic                  iReqReady,
  output logic                  iRespValid,
  output logic [WORD_WIDTH-1:0] iRespData,
  output logic                  iRespErr,
  input  logic                  dReqValid,
  input  logic                  dWrite,
  input  logic [1:0]            dUnit,
  input  logic                  dUnsigned,
  input  logic [ADDR_WIDTH-1:0] dAddr,
  input  logic [WORD_WIDTH-1:0] dWdata,
  output logic                  dReqReady,
  output logic                  dRespValid,
  output logic [WORD_WIDTH-1:0] dRespData,
  output logic                  dRespErr,
  output logic                  memRead,
  output logic                  memWrite,
  output logic [1:0]            addrUnit,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [WORD_WIDTH-1:0] dataIn,
  input  logic [WORD_WIDTH-1:0] memRdata
);

  typedef enum logic {PortInstr = 1'b0, PortData = 1'b1} port_e;

  port_e       last_grant_q;
  logic        pend_valid_q;
  port_e       pend_port_q;
  logic        pend_write_q;
  logic [1:0]  pend_unit_q;
  logic        pend_uns_q;
  logic        pend_err_q;

  logic        grant_i, grant_d;
  logic        i_err, d_err;
  logic        resp_ok;
  logic [WORD_WIDTH-1:0] ext_data, resp_data;

  // Both valid: the port that did not win last time goes first.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (rstN) begin
      if (iReqValid && (!dReqValid || last_grant_q == PortData)) begin
        grant_i = 1'b1;
      end else if (dReqValid) begin
        grant_d = 1'b1;
      end
    end
  end

  assign iReqReady = grant_i;
  assign dReqReady = grant_d;

  assign i_err = |iAddr[1:0];

  always_comb begin
    d_err = 1'b0;
    case (dUnit)
      2'b00:   d_err = 1'b0;
      2'b01:   d_err = dAddr[0];
      2'b10:   d_err = |dAddr[1:0];
      default: d_err = 1'b1;
    endcase
  end

  always_comb begin
    memRead  = (grant_i && !i_err) || (grant_d && !dWrite && !d_err);
    memWrite = grant_d && dWrite && !d_err;
    addrUnit = 2'b00;
    address  = '0;
    dataIn   = '0;
    if (grant_i) begin
      addrUnit = 2'b10;
      address  = iAddr;
    end else if (grant_d) begin
      addrUnit = dUnit;
      address  = dAddr;
      if (dWrite) dataIn = dWdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      last_grant_q <= PortData;
      pend_valid_q <= 1'b0;
      pend_port_q  <= PortInstr;
      pend_write_q <= 1'b0;
      pend_unit_q  <= 2'b00;
      pend_uns_q   <= 1'b0;
      pend_err_q   <= 1'b0;
    end else begin
      pend_valid_q <= grant_i || grant_d;
      if (grant_i) begin
        last_grant_q <= PortInstr;
        pend_port_q  <= PortInstr;
        pend_write_q <= 1'b0;
        pend_unit_q  <= 2'b10;
        pend_uns_q   <= 1'b0;
        pend_err_q   <= i_err;
      end else if (grant_d) begin
        last_grant_q <= PortData;
        pend_port_q  <= PortData;
        pend_write_q <= dWrite;
        pend_unit_q  <= dUnit;
        pend_uns_q   <= dUnsigned;
        pend_err_q   <= d_err;
      end
    end
  end

  always_comb begin
    ext_data = memRdata;
    case (pend_unit_q)
      2'b00:   ext_data = {{(WORD_WIDTH-8){memRdata[7] & !pend_uns_q}}, memRdata[7:0]};
      2'b01:   ext_data = {{(WORD_WIDTH-16){memRdata[15] & !pend_uns_q}}, memRdata[15:0]};
      default: ext_data = memRdata;
    endcase
  end

  // Holding rstN low suppresses a response that was already pending.
  assign resp_ok   = pend_valid_q && rstN;
  assign resp_data = (pend_err_q || pend_write_q) ? '0 : ext_data;

  assign iRespValid = resp_ok && (pend_port_q == PortInstr);
  assign dRespValid = resp_ok && (pend_port_q == PortData);
  assign iRespData  = iRespValid ? resp_data : '0;
  assign dRespData  = dRespValid ? resp_data : '0;
  assign iRespErr   = iRespValid && pend_err_q;
  assign dRespErr   = dRespValid && pend_err_q;

  strobe_excl_a: assert property (@(posedge clk) !(memRead && memWrite));

endmodule
